// File: rtl/lsu_rmw_pkg.sv
// Shared constants, state type and lane helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] RMEM_WORD = 5'b01111;
  localparam logic [3:0] WMEM_WORD = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    RMW_WR,
    RESP,
    ERR
  } lsu_state_t;

  // Expand a 4-bit byte-lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask32(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Request/response and memory-side signals of the load/store unit.
interface lsu_rmw_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [4:0]        rmem;
  logic [3:0]        wmem;
  logic [31:0]       store_data;
  logic [31:0]       load_data;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Execute stage plus memory: drives requests and read data.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, load_data,
    input  req_ready, mem_addr, rmem, wmem, store_data, rsp_valid, rsp_rdata, rsp_err
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, load_data,
    output req_ready, mem_addr, rmem, wmem, store_data, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_rmw_lane_decode.sv
// Byte-lane decode: lane mask, sign-extend flag and alignment/funct3 error.
module lsu_lane_decode
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       sign,
  output logic       err
);

  always_comb begin
    mask = '0;
    err  = 1'b0;
    case (funct3)
      F3_B, F3_BU: mask = 4'b0001 << addr_lo;
      F3_H, F3_HU: begin
        err  = addr_lo[0];
        mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        err  = (addr_lo != 2'b00);
        mask = 4'b1111;
      end
      default: err = 1'b1;
    endcase
    if (err) mask = '0;
    sign = (funct3 == F3_B) || (funct3 == F3_H);
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit; sub-word stores become read-modify-write with a full-word write.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 32
) (
  input  logic     clk,
  input  logic     rst,
  lsu_rmw_if.slave bus
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [MEM_AW-1:0] widx_q, widx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       old_q, old_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              sign_q, sign_d;

  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        dec_mask;
  logic              dec_sign, dec_err, req_err;
  logic [31:0]       lane_bits, wrep, merged;

  assign req_addr = bus.req_addr;

  lsu_lane_decode u_dec (
    .funct3 (bus.req_funct3),
    .addr_lo(req_addr[1:0]),
    .mask   (dec_mask),
    .sign   (dec_sign),
    .err    (dec_err)
  );

  // Unsigned sub-word codes have no store counterpart.
  assign req_err = dec_err | (bus.req_we & bus.req_funct3[2]);

  // Replicating the store value across lanes lets the lane mask alone place it.
  always_comb begin
    lane_bits = lane_mask32(mask_q);
    case (funct3_q)
      F3_W:    wrep = wdata_q;
      F3_H:    wrep = {2{wdata_q[15:0]}};
      default: wrep = {4{wdata_q[7:0]}};
    endcase
    merged = (old_q & ~lane_bits) | (wrep & lane_bits);
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    old_d    = old_q;
    rdata_d  = rdata_q;
    mask_d   = mask_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          widx_d   = MEM_AW'(req_addr >> 2);
          wdata_d  = bus.req_wdata;
          mask_d   = dec_mask;
          sign_d   = dec_sign;
          rdata_d  = '0;
          // Load/store direction is carried by the state, so we is not kept.
          if (req_err)                   state_d = ERR;
          else if (!bus.req_we)          state_d = LOAD;
          else if (bus.req_funct3 == F3_W) state_d = RMW_WR;
          else                           state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = bus.load_data;
        state_d = RESP;
      end
      RMW_RD: begin
        old_d   = bus.load_data;
        state_d = RMW_WR;
      end
      RMW_WR:    state_d = RESP;
      RESP, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      widx_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      mask_q   <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      rdata_q  <= rdata_d;
      mask_q   <= mask_d;
      sign_q   <= sign_d;
    end
  end

  always_comb begin
    bus.rmem       = '0;
    bus.wmem       = '0;
    bus.store_data = '0;
    case (state_q)
      LOAD:   bus.rmem = {sign_q, mask_q};
      RMW_RD: bus.rmem = RMEM_WORD;
      RMW_WR: begin
        bus.wmem       = WMEM_WORD;
        bus.store_data = merged;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_addr  = widx_q;
  assign bus.rsp_valid = (state_q == RESP) || (state_q == ERR);
  assign bus.rsp_err   = (state_q == ERR);
  assign bus.rsp_rdata = rdata_q;

endmodule
